// File: rtl/ncore_rst_seq_pkg.sv
// Shared types and sizing helpers for the Ncore reset sequencer.
// Holds the sequencer state encoding and the counter-width arithmetic.
package ncore_rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    DONE
  } rst_seq_state_e;

  localparam int DEF_NUM_DOM       = 4;
  localparam int DEF_ASSERT_CYCLES = 5;
  localparam int DEF_STAGE_GAP     = 4;
  localparam int DEF_DIV_W         = 4;

  // Counter widths for the default configuration.
  localparam int HOLD_W = $clog2(DEF_ASSERT_CYCLES + 1);
  localparam int GAP_W  = $clog2(DEF_STAGE_GAP + 1);
  localparam int STG_W  = $clog2(DEF_NUM_DOM + 1);

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ncore_rst_seq_if.sv
// Bundle of the sequencer's request/ack handshake, divide ratios and
// per-domain reset / clock-enable outputs.
interface ncore_rst_seq_if
  import ncore_rst_seq_pkg::*;
#(
  parameter int NUM_DOM = DEF_NUM_DOM,
  parameter int DIV_W   = DEF_DIV_W
);
  logic                       sw_rst_req;
  logic                       sw_rst_ack;
  logic [NUM_DOM*DIV_W-1:0]   div_ratio;
  logic [NUM_DOM-1:0]         dom_rst_n;
  logic [NUM_DOM-1:0]         clk_en;
  logic                       seq_done;

  modport master (
    output sw_rst_req,
    output div_ratio,
    input  sw_rst_ack,
    input  dom_rst_n,
    input  clk_en,
    input  seq_done
  );

  modport slave (
    input  sw_rst_req,
    input  div_ratio,
    output sw_rst_ack,
    output dom_rst_n,
    output clk_en,
    output seq_done
  );
endinterface

// File: rtl/ncore_clk_en_div.sv
// Per-domain clock-enable divider: one enable pulse every ratio+1 cycles
// while the domain is out of reset.
module ncore_clk_en_div
  import ncore_rst_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_fr,
  input  logic             rst,
  input  logic             rel,
  input  logic [DIV_W-1:0] ratio,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a ratio lowered below the running count fires at once.
  assign clk_en = rel && (cnt >= ratio);

  always_ff @(posedge clk_fr) begin
    if (rst || !rel) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ncore_rst_seq.sv
// Staged reset sequencer: holds all domains in reset, releases them one by one,
// and re-runs the sequence on a software request with a completion ack.
module ncore_rst_seq
  import ncore_rst_seq_pkg::*;
#(
  parameter int NUM_DOM       = DEF_NUM_DOM,
  parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP,
  parameter int DIV_W         = DEF_DIV_W
) (
  input  logic             clk_fr,
  input  logic             rst,
  ncore_rst_seq_if.slave   bus
);

  localparam int SEQ_HOLD_W = cnt_w(ASSERT_CYCLES);
  localparam int SEQ_GAP_W  = cnt_w(STAGE_GAP);
  localparam int SEQ_STG_W  = cnt_w(NUM_DOM);

  localparam logic [SEQ_HOLD_W-1:0] HOLD_LAST = SEQ_HOLD_W'(ASSERT_CYCLES);
  localparam logic [SEQ_GAP_W-1:0]  GAP_LAST  = SEQ_GAP_W'(STAGE_GAP - 1);
  localparam logic [SEQ_STG_W-1:0]  STG_ALL   = SEQ_STG_W'(NUM_DOM);

  if (NUM_DOM < 1) begin : g_chk_num_dom
    $error("ncore_rst_seq: NUM_DOM must be >= 1");
  end
  if (ASSERT_CYCLES < 1) begin : g_chk_assert_cycles
    $error("ncore_rst_seq: ASSERT_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_chk_stage_gap
    $error("ncore_rst_seq: STAGE_GAP must be >= 1");
  end
  if (DIV_W < 1) begin : g_chk_div_w
    $error("ncore_rst_seq: DIV_W must be >= 1");
  end

  rst_seq_state_e          state;
  logic [SEQ_HOLD_W-1:0]   hold;
  logic [SEQ_GAP_W-1:0]    gap;
  logic [SEQ_STG_W-1:0]    stage;   // number of domains released so far
  logic [NUM_DOM-1:0]      dom_rst_n;
  logic [NUM_DOM-1:0]      clk_en;
  logic                    seq_done;
  logic                    sw_rst_ack;
  logic                    sw_flag;

  always_ff @(posedge clk_fr) begin
    if (rst) begin
      state      <= ASSERT;
      hold       <= '0;
      gap        <= '0;
      stage      <= '0;
      dom_rst_n  <= '0;
      seq_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
      sw_flag    <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        ASSERT: begin
          if (hold == HOLD_LAST) begin
            state        <= RELEASE;
            dom_rst_n[0] <= 1'b1;
            stage        <= SEQ_STG_W'(1);
            gap          <= '0;
          end else begin
            hold <= hold + SEQ_HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (stage == STG_ALL) begin
            // Edge after the last release: sequence complete.
            state      <= DONE;
            seq_done   <= 1'b1;
            sw_rst_ack <= sw_flag;
            sw_flag    <= 1'b0;
          end else if (gap == GAP_LAST) begin
            for (int i = 0; i < NUM_DOM; i++) begin
              if (stage == SEQ_STG_W'(i)) dom_rst_n[i] <= 1'b1;
            end
            stage <= stage + SEQ_STG_W'(1);
            gap   <= '0;
          end else begin
            gap <= gap + SEQ_GAP_W'(1);
          end
        end
        DONE: begin
          // A software request replays the rst edge but remembers its origin.
          if (bus.sw_rst_req) begin
            state     <= ASSERT;
            hold      <= '0;
            gap       <= '0;
            stage     <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            sw_flag   <= 1'b1;
          end
        end
        default: begin
          state <= ASSERT;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_div
    ncore_clk_en_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk_fr (clk_fr),
      .rst    (rst),
      .rel    (dom_rst_n[i]),
      .ratio  (bus.div_ratio[i*DIV_W +: DIV_W]),
      .clk_en (clk_en[i])
    );
  end

  assign bus.dom_rst_n  = dom_rst_n;
  assign bus.clk_en     = clk_en;
  assign bus.seq_done   = seq_done;
  assign bus.sw_rst_ack = sw_rst_ack;

endmodule

// File: doc/ncore_rst_seq.md
# ncore_rst_seq

Parametrised, synthesisable reset sequencer and clock-enable generator for the Ncore testbench and DUT harness. It runs on the single free-running `clk_fr` and drives `NUM_DOM` active-low domain resets. Domains are released in staged order after a programmable hold. It also produces one divided clock-enable per domain and accepts a software re-reset request with a completion handshake.

## Interface

Parameters:

- `NUM_DOM`, 4: number of reset domains; must be ≥1.
- `ASSERT_CYCLES`, 5: cycles all domains stay in reset after reset removal; must be ≥1.
- `STAGE_GAP`, 4: cycles between consecutive domain releases; must be ≥1.
- `DIV_W`, 4: width of each per-domain divide ratio.

Ports (one clock; reset is synchronous and active-high):

- `clk_fr`  in  1  free-running clock; every register samples on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_rst_req`  in  1  level request to re-run the full sequence.
- `sw_rst_ack`  out  1  one-cycle pulse: the software-initiated sequence has completed.
- `div_ratio`  in  `NUM_DOM*DIV_W`  per-domain divide ratio; slice i is `[i*DIV_W +: DIV_W]`.
- `dom_rst_n`  out  `NUM_DOM`  active-low domain resets; bit 0 is released first.
- `clk_en`  out  `NUM_DOM`  per-domain clock-enable.
- `seq_done`  out  1  high once every domain is released.

## Operation

FSM states: ASSERT, RELEASE, DONE.

- **Reset:** `rst`=1 at an edge puts the FSM in ASSERT and clears the hold and stage counters. Registered outputs take their reset values at that edge: `dom_rst_n`=0, `seq_done`=0, `sw_rst_ack`=0, `sw_flag`=0. `clk_en` reads 0 from that edge, because all domains are in reset.
- **ASSERT:** the hold counter counts `ASSERT_CYCLES` cycles. It then moves to RELEASE and releases domain 0.
- **RELEASE:** domain k+1 is released `STAGE_GAP` cycles after domain k. Once domain `NUM_DOM-1` is released, the next edge enters DONE and sets `seq_done`=1.
- **DONE:** all outputs are steady.
  - If `sw_rst_req`=1 is sampled, that edge behaves exactly like an `rst` edge, except that `sw_flag` is set.
  - `sw_rst_ack` pulses for one cycle on the DONE-entry edge only when `sw_flag` is set. `sw_flag` clears at that edge.
  - Power-on sequences never produce an ack.
- **Request outside DONE:** `sw_rst_req` is ignored in ASSERT and RELEASE. If it is still high in DONE, the sequence restarts on the edge after the ack. The requester must drop it in the ack cycle.
- **Reset mid-sequence:** `rst`=1 at any time aborts and restarts. `sw_flag` is cleared.
- **Divider (per domain i):**
  - `cnt_i` (`DIV_W` bits) is held at 0 while `dom_rst_n[i]`=0.
  - While released: `clk_en[i] = (cnt_i >= div_ratio[i])`. When `clk_en[i]`=1, `cnt_i` wraps to 0; otherwise it increments.
  - Period is `div_ratio[i]+1` cycles. `div_ratio`=0 makes `clk_en` constantly 1.
  - The `>=` compare makes a ratio lowered mid-count take effect on the next cycle, with no 2^DIV_W stall.

## Timing

- Let E0 be the first edge where `rst`=0 is sampled. For a software request sampled at edge S, E0 = S+1.
- `dom_rst_n[i]` updates to 1 at edge E0 + `ASSERT_CYCLES` + i·`STAGE_GAP`.
- `seq_done` (and `sw_rst_ack` if applicable) update at edge E0 + `ASSERT_CYCLES` + (`NUM_DOM`-1)·`STAGE_GAP` + 1.
- `clk_en[i]` is combinational from registered state:
  - first high in the cycle after domain i's release edge, plus `div_ratio[i]` cycles;
  - no combinational path from `rst` or `sw_rst_req` to any output.
- Latency from `sw_rst_req` sampled in DONE to all `dom_rst_n`=0: one edge (the sampling edge S).

## Structure

- Package `ncore_rst_seq_pkg`:
  - `typedef enum logic [1:0] {ASSERT, RELEASE, DONE} rst_seq_state_e`;
  - localparams for hold/stage counter widths (`$clog2(ASSERT_CYCLES+1)`, `$clog2(STAGE_GAP+1)`, `$clog2(NUM_DOM+1)`).
- Sub-module `ncore_clk_en_div`, instantiated `NUM_DOM` times:
  - inputs `clk_fr`, `rst`, `rel` (= `dom_rst_n[i]`), `ratio`;
  - output `clk_en`.
- Elaboration-time assertions on the parameter minima.

## Test plan

Defaults for all scenarios unless stated: `NUM_DOM`=4, `ASSERT_CYCLES`=5, `STAGE_GAP`=4, `div_ratio` = {3,2,1,0}.

1. **Power-on:** `rst` high 3 cycles, low at E0.
   - `dom_rst_n` = 0001 at E5, 0011 at E9, 0111 at E13, 1111 at E17.
   - `seq_done` high at E18; no `sw_rst_ack`.
2. **Dividers after release:**
   - `clk_en[3]` constantly 1 from E18 onward;
   - `clk_en[2]` period 2;
   - `clk_en[0]` period 4, first pulse in the cycle after E8.
3. **Software reset:** `sw_rst_req` sampled high in DONE at edge S, dropped at ack.
   - `dom_rst_n`=0000 and `seq_done`=0 at S;
   - `dom_rst_n[0]`=1 at S+6, `dom_rst_n[3]`=1 at S+18;
   - `sw_rst_ack` one-cycle pulse at S+19;
   - no restart after the ack.
4. **Request outside DONE:** `sw_rst_req` pulsed during RELEASE → ignored; release times unchanged from scenario 1.
5. **Reset mid-sequence:** `rst` asserted at E11 (domains 0–1 released) → all `dom_rst_n`=0 and `clk_en`=0 at E11; full timing restarts from the new E0.
6. **Ratio change:** `div_ratio[0]` changed 7→2 while `cnt_0`=5 → `clk_en[0]`=1 the next cycle, then period 3.
